// File: rtl/leaf_arb_pkg.sv
// Shared packet layout, config entry type and helpers for the leaf output arbiter.
package leaf_arb_pkg;

  localparam int PAYLOAD_BITS    = 32;
  localparam int NUM_LEAF_BITS   = 5;
  localparam int NUM_PORT_BITS   = 4;
  localparam int NUM_ADDR_BITS   = 7;
  localparam int NUM_CREDIT_BITS = 8;
  localparam int PACKET_BITS     = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;

  localparam int PAYLOAD_LSB = 0;
  localparam int SEQ_LSB     = PAYLOAD_LSB + PAYLOAD_BITS;
  localparam int DPORT_LSB   = SEQ_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB    = DPORT_LSB + NUM_PORT_BITS;
  localparam int VALID_BIT   = LEAF_LSB + NUM_LEAF_BITS;

  localparam int unsigned CREDIT_MAX = (1 << NUM_CREDIT_BITS) - 1;

  typedef struct packed {
    logic                     en;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] dport;
  } cfg_entry_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  function automatic logic [PACKET_BITS-1:0] build_packet(
    input cfg_entry_t               entry,
    input logic [NUM_ADDR_BITS-1:0] seq,
    input logic [PAYLOAD_BITS-1:0]  payload
  );
    logic [PACKET_BITS-1:0] pkt;
    pkt = '0;
    pkt[VALID_BIT]                      = 1'b1;
    pkt[LEAF_LSB +: NUM_LEAF_BITS]      = entry.leaf;
    pkt[DPORT_LSB +: NUM_PORT_BITS]     = entry.dport;
    pkt[SEQ_LSB +: NUM_ADDR_BITS]       = seq;
    pkt[PAYLOAD_LSB +: PAYLOAD_BITS]    = payload;
    return pkt;
  endfunction

  // Return and consume in the same cycle combine into one net change before saturating.
  function automatic logic [NUM_CREDIT_BITS-1:0] next_credit(
    input logic [NUM_CREDIT_BITS-1:0] cur,
    input logic                       ret,
    input logic                       consume,
    input int unsigned                add
  );
    int unsigned sum;
    sum = 32'(cur);
    if (ret) sum = sum + add;
    if (consume) sum = sum - 1;
    if (sum > CREDIT_MAX) sum = CREDIT_MAX;
    return NUM_CREDIT_BITS'(sum);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_BITS = 2
) (
  input  logic [N-1:0]        req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [N-1:0]        grant,
  output logic [IDX_BITS-1:0] grant_idx,
  output logic                any_grant
);

  logic [IDX_BITS-1:0] idx;

  function automatic int unsigned wrap_idx(input logic [IDX_BITS-1:0] p, input int unsigned off);
    return (32'(p) + off) % N;
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDX_BITS'(wrap_idx(ptr, i));
      if (!any_grant && req[idx]) begin
        any_grant      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Shares the leaf-to-BFT packet channel among user output streams with
// round-robin selection, per-port credits and a runtime destination table.
module leaf_out_arbiter
  import leaf_arb_pkg::*;
#(
  parameter int          NUM_OUT_PORTS         = 4,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                  clk_user,
  input  logic                                  reset_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user,
  output logic [NUM_OUT_PORTS-1:0]              ack_user,
  output logic [PACKET_BITS-1:0]                pkt_out,
  output logic                                  pkt_valid,
  input  logic                                  pkt_ready,
  input  logic                                  credit_ret_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_ret_port,
  input  logic                                  cfg_we,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic                                  cfg_en,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dport
);

  localparam int IDX_BITS = $clog2(NUM_OUT_PORTS);

  // Handshake: a user word transfers in the cycle ack_user[k] is high (vld_user[k]
  // is already high then); a packet transfers on any edge where pkt_valid and pkt_ready are both high.
  out_state_t                 state_q, state_d;
  logic [PACKET_BITS-1:0]     pkt_q;
  logic [IDX_BITS-1:0]        rr_ptr_q;
  cfg_entry_t                 cfg_q    [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0]   seq_q    [NUM_OUT_PORTS];
  logic [NUM_CREDIT_BITS-1:0] credit_q [NUM_OUT_PORTS];
  logic [NUM_CREDIT_BITS-1:0] credit_d [NUM_OUT_PORTS];
  logic [PAYLOAD_BITS-1:0]    payload  [NUM_OUT_PORTS];

  logic [NUM_OUT_PORTS-1:0] req;
  logic [NUM_OUT_PORTS-1:0] grant;
  logic [IDX_BITS-1:0]      grant_idx;
  logic                     any_grant;
  logic                     capture_ok;
  logic                     take;

  always_comb begin
    req = '0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      req[k]     = vld_user[k] & cfg_q[k].en & (credit_q[k] != '0);
      payload[k] = din_user[k*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
  end

  rr_arbiter #(
    .N        (NUM_OUT_PORTS),
    .IDX_BITS (IDX_BITS)
  ) u_rr (
    .req       (req),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) state_q <= OUT_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    capture_ok = (state_q == OUT_EMPTY) || pkt_ready;
    take       = capture_ok && any_grant;
    ack_user   = take ? grant : '0;
    if (take) state_d = OUT_FULL;
    else if (state_q == OUT_FULL && pkt_ready) state_d = OUT_EMPTY;
  end

  always_comb begin
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      credit_d[k] = next_credit(credit_q[k],
                                credit_ret_vld && (credit_ret_port == NUM_PORT_BITS'(k)),
                                take && grant[k],
                                FREESPACE_UPDATE_SIZE);
    end
  end

  // The captured header reads cfg_q before any same-edge config write lands.
  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q    <= '0;
      rr_ptr_q <= '0;
      for (int k = 0; k < NUM_OUT_PORTS; k++) begin
        seq_q[k]    <= '0;
        credit_q[k] <= NUM_CREDIT_BITS'(FREESPACE_UPDATE_SIZE);
        cfg_q[k]    <= '0;
      end
    end else begin
      if (take) begin
        pkt_q <= build_packet(cfg_q[grant_idx], seq_q[grant_idx], payload[grant_idx]);
        if (grant_idx == IDX_BITS'(NUM_OUT_PORTS - 1)) rr_ptr_q <= '0;
        else                                           rr_ptr_q <= grant_idx + 1'b1;
      end else if (state_d == OUT_EMPTY) begin
        pkt_q <= '0;
      end
      for (int k = 0; k < NUM_OUT_PORTS; k++) begin
        credit_q[k] <= credit_d[k];
        if (take && grant[k]) seq_q[k] <= seq_q[k] + 1'b1;
        if (cfg_we && cfg_port == NUM_PORT_BITS'(k))
          cfg_q[k] <= cfg_entry_t'{en: cfg_en, leaf: cfg_leaf, dport: cfg_dport};
      end
    end
  end

  assign pkt_out   = pkt_q;
  assign pkt_valid = (state_q == OUT_FULL);

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Bench for leaf_out_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_leaf_out_arbiter;

  localparam int N    = 4;
  localparam int FS   = 4;
  localparam int CMAX = 255;

  logic           clk;
  logic           reset_n;
  logic [N*32-1:0] din_user;
  logic [N-1:0]   vld_user;
  logic [N-1:0]   ack_user;
  logic [48:0]    pkt_out;
  logic           pkt_valid;
  logic           pkt_ready;
  logic           credit_ret_vld;
  logic [3:0]     credit_ret_port;
  logic           cfg_we;
  logic [3:0]     cfg_port;
  logic           cfg_en;
  logic [4:0]     cfg_leaf;
  logic [3:0]     cfg_dport;

  leaf_out_arbiter #(
    .NUM_OUT_PORTS         (N),
    .FREESPACE_UPDATE_SIZE (FS)
  ) dut (
    .clk_user        (clk),
    .reset_n         (reset_n),
    .din_user        (din_user),
    .vld_user        (vld_user),
    .ack_user        (ack_user),
    .pkt_out         (pkt_out),
    .pkt_valid       (pkt_valid),
    .pkt_ready       (pkt_ready),
    .credit_ret_vld  (credit_ret_vld),
    .credit_ret_port (credit_ret_port),
    .cfg_we          (cfg_we),
    .cfg_port        (cfg_port),
    .cfg_en          (cfg_en),
    .cfg_leaf        (cfg_leaf),
    .cfg_dport       (cfg_dport)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // Scoreboard and counters
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: config table, credits and sequence numbers as plain arrays;
  // the output register is a queue holding zero or one packet.
  logic [48:0] exp_q[$];
  int          grant_log[$];
  int          m_en    [N];
  logic [4:0]  m_leaf  [N];
  logic [3:0]  m_dport [N];
  int          m_seq   [N];
  int          m_credit[N];
  int          m_rr;

  task automatic model_reset();
    exp_q.delete();
    m_rr = 0;
    for (int k = 0; k < N; k++) begin
      m_en[k] = 0; m_leaf[k] = '0; m_dport[k] = '0; m_seq[k] = 0; m_credit[k] = FS;
    end
  endtask

  function automatic int find_grant();
    if (!(exp_q.size() == 0 || pkt_ready)) return -1;
    for (int i = 0; i < N; i++) begin
      int p = (m_rr + i) % N;
      if (vld_user[p] && m_en[p] != 0 && m_credit[p] != 0) return p;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int g;
    int p;
    if (!reset_n) begin
      model_reset();
    end else begin
      g = find_grant();
      if (exp_q.size() != 0 && pkt_ready) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back({1'b1, m_leaf[g], m_dport[g], 7'(m_seq[g]), din_user[g*32 +: 32]});
        grant_log.push_back(g);
        m_seq[g]    = (m_seq[g] + 1) % 128;
        m_credit[g] = m_credit[g] - 1;
        m_rr        = (g + 1) % N;
      end
      p = int'(credit_ret_port);
      if (credit_ret_vld && p < N) m_credit[p] = (m_credit[p] + FS > CMAX) ? CMAX : m_credit[p] + FS;
      p = int'(cfg_port);
      if (cfg_we && p < N) begin
        m_en[p] = int'(cfg_en); m_leaf[p] = cfg_leaf; m_dport[p] = cfg_dport;
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_ack;
    g = find_grant();
    exp_ack = '0;
    if (g >= 0) exp_ack[g] = 1'b1;
    check("ack_user", 64'(ack_user), 64'(exp_ack));
    check("pkt_valid", 64'(pkt_valid), 64'(exp_q.size() != 0));
    check("pkt_out", 64'(pkt_out), (exp_q.size() != 0) ? 64'(exp_q[0]) : 64'd0);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int port, input logic en, input logic [4:0] leaf, input logic [3:0] dport);
    cfg_we = 1'b1; cfg_port = 4'(port); cfg_en = en; cfg_leaf = leaf; cfg_dport = dport;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run_count(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      if (ack_user != '0) c++;
      tick();
    end
  endtask

  int          cnt;
  int          lg0;
  int          exp_order[8] = '{3, 0, 1, 2, 3, 0, 1, 2};
  logic [31:0] p_saved;

  initial begin
    reset_n = 1'b0; din_user = '0; vld_user = 4'b1111; pkt_ready = 1'b1;
    credit_ret_vld = 1'b0; credit_ret_port = '0;
    cfg_we = 1'b0; cfg_port = '0; cfg_en = 1'b0; cfg_leaf = '0; cfg_dport = '0;

    // Reset: no ack while held, none afterwards with every port disabled
    repeat (3) tick();
    #1;
    check("reset_ack", 64'(ack_user), 64'd0);
    check("reset_pkt_valid", 64'(pkt_valid), 64'd0);
    check("reset_pkt_out", 64'(pkt_out), 64'd0);
    reset_n = 1'b1;
    tick(); tick();
    #1;
    check("disabled_ack", 64'(ack_user), 64'd0);
    vld_user = '0;
    tick();

    // Single port
    cfg_write(2, 1'b1, 5'd5, 4'd3);
    din_user[64 +: 32] = 32'hDEADBEEF;
    vld_user = 4'b0100;
    #1;
    check("single_ack", 64'(ack_user), 64'h4);
    tick();
    vld_user = '0;
    #1;
    check("single_pkt", 64'(pkt_out), 64'({1'b1, 5'd5, 4'd3, 7'd0, 32'hDEADBEEF}));
    check("single_ack_drop", 64'(ack_user), 64'd0);
    tick();
    #1;
    check("single_drained", 64'(pkt_valid), 64'd0);

    // Round robin: pointer sits after port 2
    cfg_write(0, 1'b1, 5'd1, 4'd0);
    cfg_write(1, 1'b1, 5'd2, 4'd1);
    cfg_write(3, 1'b1, 5'd3, 4'd2);
    lg0 = grant_log.size();
    for (int k = 0; k < N; k++) din_user[k*32 +: 32] = $urandom();
    vld_user = 4'b1111;
    run_count(8, cnt);
    check("rr_count", 64'(cnt), 64'd8);
    for (int i = 0; i < 8; i++)
      check("rr_order", 64'(grant_log[lg0 + i]), 64'(exp_order[i]));
    vld_user = '0;
    tick(); tick();

    // Backpressure: port 3 captured, then held for 5 cycles
    pkt_ready = 1'b0;
    vld_user  = 4'b1111;
    din_user[96 +: 32] = $urandom();
    p_saved = din_user[96 +: 32];
    #1;
    check("bp_first_ack", 64'(ack_user), 64'h8);
    tick();
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < N; k++) din_user[k*32 +: 32] = $urandom();
      #1;
      check("bp_ack_zero", 64'(ack_user), 64'd0);
      check("bp_hold", 64'(pkt_out[31:0]), 64'(p_saved));
      tick();
    end
    pkt_ready = 1'b1;
    p_saved = din_user[31:0];
    #1;
    check("bp_release_ack", 64'(ack_user), 64'h1);
    tick();
    vld_user = '0;
    #1;
    check("bp_next_payload", 64'(pkt_out[31:0]), 64'(p_saved));
    check("bp_next_seq", 64'(pkt_out[38:32]), 64'd2);
    tick(); tick();

    // Credits, from a fresh reset
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    cfg_write(0, 1'b1, 5'd7, 4'd9);
    vld_user = 4'b0001;
    run_count(8, cnt);
    check("credit_exhaust", 64'(cnt), 64'd4);
    vld_user = '0; credit_ret_vld = 1'b1; credit_ret_port = 4'd0;
    tick();
    credit_ret_vld = 1'b0; vld_user = 4'b0001;
    run_count(3, cnt);
    check("credit_after_ret", 64'(cnt), 64'd3);
    credit_ret_vld = 1'b1;
    #1;
    check("credit_coincident_ack", 64'(ack_user), 64'h1);
    tick();
    credit_ret_vld = 1'b0;
    run_count(8, cnt);
    check("credit_net_change", 64'(cnt), 64'd4);
    vld_user = '0; credit_ret_vld = 1'b1;
    repeat (70) tick();
    credit_ret_vld = 1'b0; vld_user = 4'b0001;
    run_count(270, cnt);
    check("credit_saturate", 64'(cnt), 64'd255);
    vld_user = '0;
    tick(); tick();

    // Sequence wrap on port 1
    cfg_write(0, 1'b0, 5'd0, 4'd0);
    cfg_write(1, 1'b1, 5'd4, 4'd4);
    vld_user = 4'b0010; credit_ret_vld = 1'b1; credit_ret_port = 4'd1;
    for (int i = 0; i < 130; i++) begin
      din_user[32 +: 32] = $urandom();
      #1;
      check("seq_ack", 64'(ack_user), 64'h2);
      tick();
      check("seq_wrap", 64'(pkt_out[38:32]), 64'(i % 128));
    end
    vld_user = '0; credit_ret_vld = 1'b0;
    tick(); tick();

    // Randomized traffic, with a reset pulse in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) reset_n = 1'b0;
      if (i == 1502) reset_n = 1'b1;
      for (int k = 0; k < N; k++) din_user[k*32 +: 32] = $urandom();
      vld_user        = 4'($urandom());
      pkt_ready       = ($urandom_range(0, 3) != 0);
      credit_ret_vld  = ($urandom_range(0, 7) == 0);
      credit_ret_port = 4'($urandom_range(0, 5));
      cfg_we          = ($urandom_range(0, 15) == 0);
      cfg_port        = 4'($urandom_range(0, 5));
      cfg_en          = ($urandom_range(0, 3) != 0);
      cfg_leaf        = 5'($urandom());
      cfg_dport       = 4'($urandom());
      tick();
    end
    vld_user = '0; cfg_we = 1'b0; credit_ret_vld = 1'b0; pkt_ready = 1'b1;
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
